// File: rtl/rf_seq_ctrl.sv
// Instruction sequencer for a register-file datapath: latches an instruction and steps the
// datapath strobes through read, ALU and write-back. Define RF_CTRL_ERR_EN to trap illegal encodings.
module rf_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] instr,
    output logic        in_ready,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic [15:0] sximm8,
    output logic        busy,
    output logic        done
`ifdef RF_CTRL_ERR_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StGetA,
        StGetB,
        StAlu,
        StWrImm,
        StWrReg,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StWait;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StWait && in_valid) begin
                ir_q <= instr;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        aluop    = 2'b00;
        done     = 1'b0;
        unique case (state_q)
            StWait: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StDecode;
            end
            StDecode: begin
                if (is_mov_imm)               state_d = StWrImm;
                else if (is_mov_reg || is_mvn) state_d = StGetB;
                else if (is_alu)               state_d = StGetA;
                else begin
`ifdef RF_CTRL_ERR_EN
                    state_d = StErr;
`else
                    done    = 1'b1;
                    state_d = StWait;
`endif
                end
            end
            StGetA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = StGetB;
            end
            StGetB: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = StAlu;
            end
            StAlu: begin
                // MOV-reg and MVN are unary: zero the A operand, MOV passes B through ADD
                asel  = is_mov_reg || is_mvn;
                aluop = is_mov_reg ? 2'b00 : op;
                loadc = !is_cmp;
                loads = is_cmp;
                if (is_cmp) begin
                    done    = 1'b1;
                    state_d = StWait;
                end else begin
                    state_d = StWrReg;
                end
            end
            StWrImm: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
                done     = 1'b1;
                state_d  = StWait;
            end
            StWrReg: begin
                writenum = rd;
                write    = 1'b1;
                done     = 1'b1;
                state_d  = StWait;
            end
            StErr: state_d = StErr;
            default: state_d = StWait;
        endcase
    end

    assign busy   = ~in_ready;
    assign shift  = ir_q[4:3];
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

`ifdef RF_CTRL_ERR_EN
    assign err = (state_q == StErr);
`endif

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Self-checking bench for rf_seq_ctrl: per-cycle expected outputs are queued when an
// instruction is issued and compared as the controller steps through its states.
module tb_rf_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] instr;
    logic        in_ready;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [1:0]  shift, aluop;
    logic [15:0] sximm8;
    logic        busy, done;
`ifdef RF_CTRL_ERR_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    rf_seq_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .instr    (instr),
        .in_ready (in_ready),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .aluop    (aluop),
        .sximm8   (sximm8),
        .busy     (busy),
        .done     (done)
`ifdef RF_CTRL_ERR_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] ctl;   // {in_ready, busy, done, write, loada, loadb, loadc, loads}
        logic [1:0] sh;
        logic [15:0] sx;
        bit         c_rd;
        logic [2:0] rdn;
        bit         c_wn;
        logic [2:0] wrn;
        bit         c_alu;
        logic [3:0] alu;   // {aluop, asel, bsel}
        bit         c_vs;
        logic       vs;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t base(input string tag, input logic [15:0] ins);
        exp_t e;
        e.tag   = $sformatf("%h.%s", ins, tag);
        e.ctl   = 8'b0100_0000;
        e.sh    = ins[4:3];
        e.sx    = {{8{ins[7]}}, ins[7:0]};
        e.c_rd  = 0; e.rdn = '0;
        e.c_wn  = 0; e.wrn = '0;
        e.c_alu = 0; e.alu = '0;
        e.c_vs  = 0; e.vs  = 1'b0;
        return e;
    endfunction

    // Reference sequence for one instruction, ending with the WAIT cycle that follows it
    task automatic push_exp(input logic [15:0] ins);
        exp_t       e;
        logic [2:0] opc = ins[15:13];
        logic [1:0] op  = ins[12:11];
        bit mov_imm = (opc == 3'b110) && (op == 2'b10);
        bit mov_reg = (opc == 3'b110) && (op == 2'b00);
        bit alu     = (opc == 3'b101);
        bit cmp     = alu && (op == 2'b01);
        bit unary   = mov_reg || (alu && op == 2'b11);
        e = base("decode", ins);
        if (!(mov_imm || mov_reg || alu)) e.ctl = 8'b0110_0000;
        q.push_back(e);
        if (mov_imm) begin
            e = base("wr_imm", ins);
            e.ctl = 8'b0111_0000; e.c_wn = 1; e.wrn = ins[10:8]; e.c_vs = 1; e.vs = 1'b1;
            q.push_back(e);
        end else if (mov_reg || alu) begin
            if (!unary) begin
                e = base("get_a", ins);
                e.ctl = 8'b0100_1000; e.c_rd = 1; e.rdn = ins[10:8];
                q.push_back(e);
            end
            e = base("get_b", ins);
            e.ctl = 8'b0100_0100; e.c_rd = 1; e.rdn = ins[2:0];
            q.push_back(e);
            e = base("alu", ins);
            e.ctl = cmp ? 8'b0110_0001 : 8'b0100_0010;
            e.c_alu = 1;
            e.alu = {(mov_reg ? 2'b00 : op), unary, 1'b0};
            q.push_back(e);
            if (!cmp) begin
                e = base("wr_reg", ins);
                e.ctl = 8'b0111_0000; e.c_wn = 1; e.wrn = ins[7:5]; e.c_vs = 1; e.vs = 1'b0;
                q.push_back(e);
            end
        end
        e = base("wait", ins);
        e.ctl = 8'b1000_0000;
        q.push_back(e);
    endtask

    task automatic check_exp(input exp_t e);
        chk({e.tag, ".ctl"}, {24'd0, in_ready, busy, done, write, loada, loadb, loadc, loads},
            {24'd0, e.ctl});
        chk({e.tag, ".shift_sx"}, {14'd0, shift, sximm8}, {14'd0, e.sh, e.sx});
        if (e.c_rd)  chk({e.tag, ".readnum"}, {29'd0, readnum}, {29'd0, e.rdn});
        if (e.c_wn)  chk({e.tag, ".writenum"}, {29'd0, writenum}, {29'd0, e.wrn});
        if (e.c_alu) chk({e.tag, ".alu_sel"}, {28'd0, aluop, asel, bsel}, {28'd0, e.alu});
        if (e.c_vs)  chk({e.tag, ".vsel"}, {31'd0, vsel}, {31'd0, e.vs});
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check_exp(e);
            if (q.size() > 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Issue from a WAIT cycle; with hold set, in_valid stays high and instr switches to nxt
    task automatic run_instr(input logic [15:0] ins, input bit hold, input logic [15:0] nxt);
        in_valid = 1'b1;
        instr    = ins;
        push_exp(ins);
        @(posedge clk); #1;
        if (hold) instr = nxt;
        else      in_valid = 1'b0;
        drain();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".ctl"}, {24'd0, in_ready, busy, done, write, loada, loadb, loadc, loads},
            32'h80);
        chk({tag, ".sx"}, {16'd0, sximm8}, 32'd0);
`ifdef RF_CTRL_ERR_EN
        chk({tag, ".err"}, {31'd0, err}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        instr    = 16'hD305;
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst_hold");

        // First edge after reset release accepts the held instruction
        reset = 1'b0;
        push_exp(16'hD305);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        run_instr(16'hD2FF, 0, 16'h0000);
        run_instr(16'hA140, 0, 16'h0000);
        run_instr(16'hA900, 0, 16'h0000);
        run_instr(16'hB38D, 0, 16'h0000);
        run_instr(16'hB8F2, 0, 16'h0000);
        run_instr(16'hC0BE, 1, 16'hD2FF);
        run_instr(16'hD2FF, 0, 16'h0000);

        // Asynchronous reset in the middle of an ADD
        in_valid = 1'b1;
        instr    = 16'hA140;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_getb.loadb", {31'd0, loadb}, 32'd1);
        reset = 1'b1;
        #1;
        check_idle("rst_async");
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("rst_release");

`ifdef RF_CTRL_ERR_EN
        in_valid = 1'b1;
        instr    = 16'hE000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("illegal.decode", {24'd0, in_ready, busy, done, write, loada, loadb, loadc, loads},
            32'h40);
        in_valid = 1'b1;
        instr    = 16'hD305;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("illegal.err", {30'd0, err, in_ready}, 32'd2);
            chk("illegal.ctl", {24'd0, in_ready, busy, done, write, loada, loadb, loadc, loads},
                32'h40);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_idle("illegal.rst");
        @(posedge clk); #1;
        reset = 1'b0;
`else
        run_instr(16'hE000, 0, 16'h0000);
`endif

        run_instr(16'hD305, 0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_seq_ctrl.md
RF_SEQ_CTRL -- requirements
Module: rf_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: instruction offered.
REQ-004 SHALL have port instr, input, 16 bits: instruction word with fields opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
REQ-005 SHALL have port in_ready, output, 1 bit: controller can accept an instruction.
REQ-006 SHALL have ports readnum and writenum, outputs, 3 bits each: register-file read and write addresses.
REQ-007 SHALL have port write, output, 1 bit: register-file write strobe.
REQ-008 SHALL have ports loada, loadb, loadc and loads, outputs, 1 bit each: datapath register load strobes.
REQ-009 SHALL have ports asel and bsel, outputs, 1 bit each: asel=1 forces A operand to 0; bsel=1 selects sximm8 as B operand.
REQ-010 SHALL have port vsel, output, 1 bit: 0 selects C as write-back source, 1 selects sximm8.
REQ-011 SHALL have ports shift and aluop, outputs, 2 bits each.
REQ-012 SHALL have port sximm8, output, 16 bits: sign-extended IR imm8.
REQ-013 SHALL have ports busy and done, outputs, 1 bit each.
REQ-014 SHALL have port err, output, 1 bit; present only when RF_CTRL_ERR_EN is defined.

Function
REQ-015 SHALL accept an instruction on the rising edge where in_valid=1 and in_ready=1, latching instr into an internal 16-bit IR.
REQ-016 SHALL assert in_ready only in state WAIT.
REQ-017 SHALL implement FSM states WAIT, DECODE, GET_A, GET_B, ALU, WR_IMM, WR_REG, and ERR (ERR only with the macro).
REQ-018 SHALL make all outputs Moore outputs, decoded from the current state and IR only.
REQ-019 SHALL derive shift, aluop, sximm8 and all addresses from IR, never from instr directly.
REQ-020 SHALL sequence MOV Rn,#imm8 (opcode 110, op 10) as DECODE -> WR_IMM -> WAIT; WR_IMM: writenum=Rn, vsel=1, write=1.
REQ-021 SHALL sequence MOV Rd,Rm (opcode 110, op 00) as DECODE -> GET_B -> ALU -> WR_REG -> WAIT.
REQ-022 SHALL sequence ADD (opcode 101, op 00) and AND (opcode 101, op 10) as DECODE -> GET_A -> GET_B -> ALU -> WR_REG -> WAIT.
REQ-023 SHALL sequence CMP (opcode 101, op 01) as DECODE -> GET_A -> GET_B -> ALU -> WAIT, with loads=1 and loadc=0 in ALU.
REQ-024 SHALL sequence MVN (opcode 101, op 11) as DECODE -> GET_B -> ALU -> WR_REG -> WAIT.
REQ-025 In GET_A SHALL drive readnum=Rn and loada=1; in GET_B, readnum=Rm and loadb=1.
REQ-026 In ALU SHALL drive loadc=1 (except CMP) and asel=1 for MOV-reg and MVN, asel=0 otherwise; bsel=0.
REQ-027 In ALU SHALL drive aluop=00 for MOV-reg, otherwise aluop=op.
REQ-028 SHALL drive shift=IR[4:3] in every state; in WR_REG, writenum=Rd, vsel=0, write=1.
REQ-029 SHALL deassert every strobe (write, loada/b/c, loads) in all states other than those stated above.
REQ-030 SHALL assert done for exactly one cycle, in the final state of each instruction (WR_IMM, WR_REG, or ALU for CMP).
REQ-031 SHALL drive busy = NOT in_ready.
REQ-032 SHALL ignore in_valid while busy; a held in_valid is accepted in the first WAIT cycle, giving back-to-back issue with no gap.

Reset
REQ-033 Reset SHALL take effect asynchronously: state=WAIT, IR=0, err=0, all strobes 0, done=0, in_ready=1, regardless of the in-progress state.
REQ-034 While reset is high SHALL accept no instruction; the first accept SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-035 Macro RF_CTRL_ERR_EN defined: an illegal encoding (opcode not 110/101, or opcode 110 with op 01/11) SHALL go DECODE -> ERR; in ERR, err=1, in_ready=0, no strobes, and the state SHALL be held until reset.
REQ-036 Macro RF_CTRL_ERR_EN undefined: an illegal encoding SHALL go DECODE -> WAIT with done=1 in DECODE, no strobes, and no err port.

Verification
REQ-037 SHALL verify: accept 0xD305 (MOV R3,#5) -> WR_IMM two cycles after accept, writenum=3, vsel=1, write=1, sximm8=0x0005, done=1.
REQ-038 SHALL verify: 0xD2FF (MOV R2,#-1) -> sximm8=0xFFFF.
REQ-039 SHALL verify: ADD R2,R1,R0 (0xA140) -> GET_A readnum=1, GET_B readnum=0, then ALU aluop=00 loadc=1, then WR_REG writenum=2; done 5 cycles after accept.
REQ-040 SHALL verify: CMP R1,R0 (0xA900) -> ALU loads=1, loadc=0, and no write in any cycle.
REQ-041 SHALL verify: in_valid held high across two instructions -> second accepted in the cycle immediately after the first's done; assert reset during GET_B -> same cycle state=WAIT and all strobes 0.
REQ-042 SHALL verify: 0xE000 with the macro -> err=1 stays set and in_ready=0 until reset; without the macro -> done pulse in DECODE, then back in WAIT.
